// File: rtl/cmd_pkg.sv
// Shared constants, state encoding and helpers for the command packetizer.
// Build option: define CMD_CHECKSUM_EN to append '*' and a two-digit hex XOR checksum.
package cmd_pkg;

    localparam logic [7:0] ASC_X     = 8'h58;
    localparam logic [7:0] ASC_Y     = 8'h59;
    localparam logic [7:0] ASC_COMMA = 8'h2C;
    localparam logic [7:0] ASC_STAR  = 8'h2A;
    localparam logic [7:0] ASC_NL    = 8'h0A;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_A     = 8'h41;

    typedef enum logic [1:0] {
        IDLE,
        CONV_X,
        CONV_Y,
        SEND
    } state_t;

    function automatic int frame_len(int digits);
`ifdef CMD_CHECKSUM_EN
        return 2 * digits + 7;
`else
        return 2 * digits + 4;
`endif
    endfunction

    function automatic int sat_limit(int digits);
        int v;
        v = 1;
        for (int i = 0; i < digits; i++) v = v * 10;
        return v - 1;
    endfunction

    function automatic logic [7:0] dec_ascii(logic [3:0] n);
        return ASC_0 + {4'h0, n};
    endfunction

    function automatic logic [7:0] hex_ascii(logic [3:0] n);
        if (n < 4'd10) return ASC_0 + {4'h0, n};
        return ASC_A + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: start loads din and shifts its MSB; W-1 more shifts follow.
// Ports: clk, reset, start, din[W], done (1-cycle pulse after last shift), bcd (4 digits).
module bin2bcd_seq #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] din,
    output logic         done,
    output logic [15:0]  bcd
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  sh;
    logic [CW-1:0] cnt;
    logic          run;
    logic [15:0]   adjd;

    // Add-3 correction on every digit that is 5 or more before shifting.
    always_comb begin
        adjd = bcd;
        for (int i = 0; i < 4; i++) begin
            if (adjd[4*i +: 4] >= 4'd5) adjd[4*i +: 4] = adjd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh   <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
            bcd  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // First shift needs no correction: the BCD register is empty.
                bcd <= {15'd0, din[W-1]};
                sh  <= din << 1;
                cnt <= CW'(W - 1);
                run <= (W > 1);
                if (W == 1) done <= 1'b1;
            end else if (run) begin
                bcd <= {adjd[14:0], sh[W-1]};
                sh  <= sh << 1;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/command_packetizer.sv
// Converts one (x, y) command to an ASCII frame "Xddd,Yddd\n" streamed over valid/ready.
// Ports: cmd_x/cmd_y/cmd_valid/cmd_ready in, byte_data/byte_valid/byte_ready out, busy.
// Build option: CMD_CHECKSUM_EN inserts "*HH" (XOR of 'X'..last y digit) before '\n'.
module command_packetizer
    import cmd_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int DIGITS  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] cmd_x,
    input  logic [COORD_W-1:0] cmd_y,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    output logic [7:0]         byte_data,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic               busy
);

    localparam int LIM  = sat_limit(DIGITS);
    localparam int LAST = frame_len(DIGITS) - 1;
    localparam logic [COORD_W-1:0] LIM_V = COORD_W'(LIM);

    state_t               state, state_n;
    logic                 conv_start, conv_done;
    logic [COORD_W-1:0]   conv_din, y_reg;
    logic [15:0]          conv_bcd, x_bcd;
    logic [3:0]           idx;
    logic                 xfer, last;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    function automatic logic [COORD_W-1:0] sat(logic [COORD_W-1:0] v);
        return (int'(v) > LIM) ? LIM_V : v;
    endfunction

    // y digits are read straight from the converter, which holds them after y finishes.
    function automatic logic [7:0] frame_byte(int i);
        logic [7:0] b;
        b = ASC_NL;
        if (i == 0) b = ASC_X;
        else if (i <= DIGITS) b = dec_ascii(x_bcd[4*(DIGITS-i) +: 4]);
        else if (i == DIGITS + 1) b = ASC_COMMA;
        else if (i == DIGITS + 2) b = ASC_Y;
        else if (i <= 2*DIGITS + 2) b = dec_ascii(conv_bcd[4*(2*DIGITS+2-i) +: 4]);
`ifdef CMD_CHECKSUM_EN
        else if (i == 2*DIGITS + 3) b = ASC_STAR;
        else if (i == 2*DIGITS + 4) b = hex_ascii(csum[7:4]);
        else if (i == 2*DIGITS + 5) b = hex_ascii(csum[3:0]);
`endif
        return b;
    endfunction

    bin2bcd_seq #(.W(COORD_W)) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .din   (conv_din),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign xfer      = (state == SEND) && byte_valid && byte_ready;
    assign last      = (int'(idx) == LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        conv_start = 1'b0;
        conv_din   = sat(cmd_x);
        unique case (state)
            IDLE: if (cmd_valid) begin
                state_n    = CONV_X;
                conv_start = 1'b1;
            end
            CONV_X: if (conv_done) begin
                state_n    = CONV_Y;
                conv_start = 1'b1;
                conv_din   = y_reg;
            end
            CONV_Y: if (conv_done) state_n = SEND;
            SEND:   if (xfer && last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_reg      <= '0;
            x_bcd      <= '0;
            idx        <= '0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
`ifdef CMD_CHECKSUM_EN
            csum       <= 8'h00;
`endif
        end else begin
            if (state == IDLE && cmd_valid) begin
                y_reg <= sat(cmd_y);
`ifdef CMD_CHECKSUM_EN
                csum  <= 8'h00;
`endif
            end
            if (state == CONV_X && conv_done) x_bcd <= conv_bcd;
            if (state == SEND) begin
                if (!byte_valid) begin
                    byte_valid <= 1'b1;
                    byte_data  <= frame_byte(int'(idx));
                end else if (byte_ready) begin
`ifdef CMD_CHECKSUM_EN
                    if (int'(idx) <= 2*DIGITS + 2) csum <= csum ^ byte_data;
`endif
                    if (last) begin
                        byte_valid <= 1'b0;
                        idx        <= '0;
                    end else begin
                        idx       <= idx + 4'd1;
                        byte_data <= frame_byte(int'(idx) + 1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_command_packetizer.sv
// Randomized self-checking bench for command_packetizer against a text-frame model.
// Honours CMD_CHECKSUM_EN in the model when the design is built with it.
module tb_command_packetizer;

    localparam int COORD_W = 10;
    localparam int DIGITS  = 3;
    localparam int LAT     = 2 * COORD_W + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic [COORD_W-1:0] cmd_x, cmd_y;
    logic               cmd_valid, cmd_ready;
    logic [7:0]         byte_data;
    logic               byte_valid, byte_ready, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    command_packetizer #(.COORD_W(COORD_W), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy)
    );

    task automatic frame_model(input int x, input int y, output logic [7:0] f[$]);
        int lim, p;
        logic [7:0] cs;
        string hx;
        hx = "0123456789ABCDEF";
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        lim = lim - 1;
        if (x > lim) x = lim;
        if (y > lim) y = lim;
        f = {};
        f.push_back("X");
        p = lim + 1;
        for (int k = 0; k < DIGITS; k++) begin
            p = p / 10;
            f.push_back(8'(48 + (x / p) % 10));
        end
        f.push_back(",");
        f.push_back("Y");
        p = lim + 1;
        for (int k = 0; k < DIGITS; k++) begin
            p = p / 10;
            f.push_back(8'(48 + (y / p) % 10));
        end
`ifdef CMD_CHECKSUM_EN
        cs = 8'h00;
        foreach (f[i]) cs = cs ^ f[i];
        f.push_back("*");
        f.push_back(hx[cs[7:4]]);
        f.push_back(hx[cs[3:0]]);
`endif
        f.push_back(8'h0a);
    endtask

    // Called just after a negedge; returns just after the negedge following the accept edge.
    task automatic send_cmd(input int x, input int y);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL cmd_ready_before_send got=%b exp=1", cmd_ready);
        end
        cmd_x = COORD_W'(x);
        cmd_y = COORD_W'(y);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Receives bytes until '\n' (or max_n bytes), stalling 'stall' cycles after each transfer.
    task automatic collect(input int stall, input int max_n, input bit noise,
                           output logic [7:0] q[$], output int lat);
        int edges, hold;
        bit have, done;
        logic [7:0] held;
        edges = 0; hold = 0; have = 0; done = 0; lat = -1; held = 8'h00;
        q = {};
        while (!done && edges < 3000) begin
            byte_ready = (hold == 0);
            if (have) begin
                total++;
                if (byte_valid !== 1'b1 || byte_data !== held) begin
                    bad++;
                    $display("FAIL stall_hold got=%b/%h exp=1/%h", byte_valid, byte_data, held);
                end
            end
            if (byte_valid === 1'b1 && lat < 0) lat = edges;
            if (noise) begin
                total++;
                if (cmd_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL cmd_ready_busy got=%b exp=0", cmd_ready);
                end
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_x = COORD_W'($urandom);
                cmd_y = COORD_W'($urandom);
            end
            have = 0;
            if (byte_valid === 1'b1 && byte_ready) begin
                q.push_back(byte_data);
                hold = stall;
                if (byte_data == 8'h0a || (max_n > 0 && q.size() == max_n)) done = 1;
            end else begin
                if (byte_valid === 1'b1) begin
                    have = 1;
                    held = byte_data;
                end
                if (hold > 0) hold--;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        byte_ready = 1'b1;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL collect_timeout got=%0d bytes exp=frame", q.size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({cmd_ready, byte_valid, busy, byte_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_vals got=%b%b%b/%h exp=100/00",
                     cmd_ready, byte_valid, busy, byte_data);
        end
        reset = 1'b0;
        byte_ready = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({byte_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL idle_ready_noeffect got=%b%b exp=00", byte_valid, busy);
        end
    endtask

    task automatic run_frame(input string nm, input int x, input int y,
                             input int stall, input bit noise);
        logic [7:0] q[$], e[$];
        int lat;
        frame_model(x, y, e);
        send_cmd(x, y);
        collect(stall, 0, noise, q, lat);
        total++;
        if (q.size() != e.size()) begin
            bad++;
            $display("FAIL %s_len got=%0d exp=%0d", nm, q.size(), e.size());
        end
        for (int i = 0; i < q.size() && i < e.size(); i++) begin
            total++;
            if (q[i] !== e[i]) begin
                bad++;
                $display("FAIL %s_byte%0d got=%h exp=%h", nm, i, q[i], e[i]);
            end
        end
        total++;
        if (lat != LAT) begin
            bad++;
            $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, LAT);
        end
        total++;
        if ({cmd_ready, busy, byte_valid} !== 3'b100) begin
            bad++;
            $display("FAIL %s_after_nl got=%b%b%b exp=100", nm, cmd_ready, busy, byte_valid);
        end
    endtask

    task automatic test_basic;
        run_frame("basic", 123, 45, 0, 0);
    endtask

    task automatic test_saturation;
        run_frame("sat", 1023, 0, 0, 0);
        run_frame("sat_edge", 999, 1000, 0, 0);
    endtask

    task automatic test_stall;
        run_frame("stall", 123, 45, 50, 0);
    endtask

    task automatic test_ignore;
        bit extra;
        run_frame("ignore", 123, 45, 1, 1);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (byte_valid !== 1'b0 || busy !== 1'b0) extra = 1;
        end
        total++;
        if (extra) begin
            bad++;
            $display("FAIL ignore_second_frame got=1 exp=0");
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] q[$], e[$];
        int lat;
        frame_model(123, 45, e);
        send_cmd(123, 45);
        collect(0, 4, 0, q, lat);
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            total++;
            if (q[i] !== e[i]) begin
                bad++;
                $display("FAIL rmid_byte%0d got=%h exp=%h", i, q[i], e[i]);
            end
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({byte_valid, cmd_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL rmid_abort got=%b%b%b exp=010", byte_valid, cmd_ready, busy);
        end
        run_frame("after_reset", 7, 8, 0, 0);
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 8; n++) begin
            int x, y;
            x = (n == 0) ? 0 : int'($urandom_range(0, 1023));
            y = (n == 1) ? 1023 : int'($urandom_range(0, 1023));
            run_frame("b2b", x, y, int'($urandom_range(0, 2)), 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_x = '0;
        cmd_y = '0;
        byte_ready = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_saturation;
        test_stall;
        test_ignore;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
